por_seq: RTL and testbench
==========================

Name: por_seq

Overview:
- Reset-release sequencer downstream of the POR one-shot.
- After the POR reports timeout, releases N_DOM reset domains one at a time, spaced by a fixed gap.
- Monitors a raw brownout comparator and owns the trip-voltage code (otrip) fed to the POR analog/decoder.
- Accepts otrip updates over a req/ack handshake, with brownout blanking after each change.

Parameters:
- N_DOM, 4: number of sequenced reset domains (1..8).
- GAP_CYCLES, 16: osc_ck cycles between successive domain releases (>=2).
- BLANK_CYCLES, 32: brownout-ignore window after an otrip change (>=1).
- BOD_FILT, 4: consecutive synchronized-high samples that qualify a brownout (>=1).
- OTRIP_RST, 3'b011: otrip value after reset.

Ports:
- osc_ck  in  1  clock (POR RC oscillator).
- rsb  in  1  synchronous active-low reset.
- por_timed_out  in  1  POR sequence complete (level).
- bod_trip  in  1  raw brownout comparator, asynchronous.
- cfg_req  in  1  otrip update request (level, held until ack).
- cfg_otrip  in  3  requested trip code.
- cfg_ack  out  1  one-cycle acknowledge.
- otrip  out  3  applied trip code.
- rst_n  out  N_DOM  per-domain active-low resets.
- bod_event  out  1  one-cycle pulse per qualified brownout.
- bod_count  out  8  saturating brownout count.
- seq_state  out  3  current FSM state (debug).

Behaviour:
- Reset (rsb=0 at a posedge):
  - state=WAIT_POR, rst_n=0, otrip=OTRIP_RST, cfg_ack=0, bod_event=0, bod_count=0.
  - Gap counter, blank counter, filter counter and domain index all cleared; sync flops cleared.
- bod_trip path: 2-flop synchronizer produces bod_s.
  - Filter counter increments while bod_s=1 and clears when bod_s=0.
  - "qualified" means filter counter==BOD_FILT; the counter saturates there.
  - In RUN, state changes at the edge where qualified is first seen. bod_trip high from edge E0 gives rst_n low at edge E0+BOD_FILT+2.
- Global priority: in any state except WAIT_POR, por_timed_out=0 forces rst_n=0 and WAIT_POR on the next edge. This overrides everything else.
- WAIT_POR: when por_timed_out=1, go to STAGGER with gap=0, idx=0.
- STAGGER:
  - gap increments each cycle. When gap==GAP_CYCLES-1: rst_n[idx]<=1, idx++, gap<=0.
  - rst_n[k] rises (k+1)*GAP_CYCLES cycles after STAGGER entry.
  - On the edge releasing domain N_DOM-1, go to RUN.
  - Brownout is not monitored in STAGGER.
- RUN:
  - qualified: rst_n<=0, bod_event<=1 for one cycle, bod_count<=min(bod_count+1,255), go to BROWNOUT.
  - Else if cfg_req: otrip<=cfg_otrip, cfg_ack<=1 for one cycle, filter counter cleared, blank=0, go to BLANK.
  - Brownout beats cfg_req on the same cycle; the request stays pending.
- BLANK:
  - Filter counter held at 0.
  - After BLANK_CYCLES cycles, return to RUN.
  - cfg_req is not acked in BLANK.
- BROWNOUT: rst_n held 0. When bod_s=0 for BOD_FILT consecutive cycles, go to STAGGER (full re-release).
- cfg_req seen outside RUN stays pending and is acked only on a RUN cycle. The requester must drop cfg_req within one cycle of ack, otherwise the request is re-accepted.
- All outputs are registered.

Optional Feature:
- Macro: POR_SEQ_BOD_STICKY_EN.
- Defined: BROWNOUT exits only when bod_s has been clear for BOD_FILT consecutive cycles AND cfg_req=1 on the same cycle. That cycle loads otrip<=cfg_otrip and pulses cfg_ack, then goes to STAGGER. This gives a software-acknowledged recovery with a new trip point.
- Undefined: automatic exit as described under Behaviour; cfg_req is ignored in BROWNOUT.

Decomposition:
- Package por_seq_pkg:
  - State enum, 3 bits: WAIT_POR=0, STAGGER=1, RUN=2, BLANK=3, BROWNOUT=4.
  - OTRIP_W=3.
  - BOD_CNT_W=8 and BOD_CNT_MAX=255.
- One sub-module por_seq_filt: synchronizer plus consecutive-sample filter. Outputs: bod_s, qualified, clear-qualified. Has a clear input used by BLANK.

Test Plan:
- Release sequence: rsb low 3 cycles, then por_timed_out=1 at cycle 10 → with the 1-cycle transition into STAGGER, rst_n=0001/0011/0111/1111 at cycles 27/43/59/75 relative to reset release; seq_state=2 at cycle 75.
- Brownout filter:
  - bod_trip high 3 cycles in RUN → no change.
  - bod_trip high 10 cycles → rst_n=0000 at edge E0+6, bod_event one pulse, bod_count=1.
  - After bod_trip is clear for 4 cycles, the staggered re-release completes.
- Config: in RUN, cfg_req=1 with cfg_otrip=3'b110 → otrip=110 and cfg_ack one pulse at the next edge. bod_trip high during the following 32 cycles produces no bod_event.
- Pending config: cfg_req asserted in STAGGER → no ack until the first RUN cycle, then one ack.
- POR loss: por_timed_out=0 while in RUN or BLANK → rst_n=0000 and seq_state=0 at the next edge; recovery repeats the test-1 timing.
- Saturation: 260 qualified brownouts → bod_count stays 255.
- Sticky build (POR_SEQ_BOD_STICKY_EN): remains in BROWNOUT until cfg_req=1; then otrip is loaded and STAGGER is entered.

Source files
------------

// File: rtl/por_seq_pkg.sv
// Shared types and constants for the POR reset-release sequencer.
package por_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_POR = 3'd0,
    STAGGER  = 3'd1,
    RUN      = 3'd2,
    BLANK    = 3'd3,
    BROWNOUT = 3'd4
  } state_e;

  localparam int OTRIP_W     = 3;
  localparam int BOD_CNT_W   = 8;
  localparam int BOD_CNT_MAX = 255;

  function automatic logic [BOD_CNT_W-1:0] sat_inc(input logic [BOD_CNT_W-1:0] v);
    return (v == BOD_CNT_W'(BOD_CNT_MAX)) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/por_seq_filt.sv
// Brownout comparator synchronizer plus consecutive-sample filters for
// assertion (qual_o) and de-assertion (clear_o) of the synchronized level.
module por_seq_filt #(
  parameter int BOD_FILT = 4
) (
  input  logic clk_i,
  input  logic rsb_i,
  input  logic bod_trip_i,
  input  logic clr_i,
  output logic bod_s_o,
  output logic qual_o,
  output logic clear_o
);

  localparam int CW = $clog2(BOD_FILT + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] hi_q, hi_d, lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (clr_i || !sync2_q)           hi_d = '0;
    else if (hi_q != CW'(BOD_FILT))  hi_d = hi_q + 1'b1;
    if (sync2_q)                     lo_d = '0;
    else if (lo_q != CW'(BOD_FILT))  lo_d = lo_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rsb_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      sync1_q <= bod_trip_i;
      sync2_q <= sync1_q;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bod_s_o = sync2_q;
  assign qual_o  = (hi_q == CW'(BOD_FILT));
  assign clear_o = (lo_q == CW'(BOD_FILT));

endmodule

// File: rtl/por_seq.sv
// Reset-release sequencer: staggers N_DOM domain resets after POR timeout,
// filters brownout, owns otrip. POR_SEQ_BOD_STICKY_EN makes brownout recovery wait for cfg_req.
module por_seq
  import por_seq_pkg::*;
#(
  parameter int                 N_DOM        = 4,
  parameter int                 GAP_CYCLES   = 16,
  parameter int                 BLANK_CYCLES = 32,
  parameter int                 BOD_FILT     = 4,
  parameter logic [OTRIP_W-1:0] OTRIP_RST    = 3'b011
) (
  input  logic                 osc_ck,
  input  logic                 rsb,
  input  logic                 por_timed_out,
  input  logic                 bod_trip,
  input  logic                 cfg_req,
  input  logic [OTRIP_W-1:0]   cfg_otrip,
  output logic                 cfg_ack,
  output logic [OTRIP_W-1:0]   otrip,
  output logic [N_DOM-1:0]     rst_n,
  output logic                 bod_event,
  output logic [BOD_CNT_W-1:0] bod_count,
  output logic [2:0]           seq_state
);

  localparam int GW    = $clog2(GAP_CYCLES);
  localparam int BW    = $clog2(BLANK_CYCLES + 1);
  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  state_e                 state_q, state_d;
  logic [N_DOM-1:0]       rst_n_q, rst_n_d;
  logic [OTRIP_W-1:0]     otrip_q, otrip_d;
  logic                   ack_q, ack_d, evt_q, evt_d;
  logic [BOD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [BW-1:0]          blank_q, blank_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   filt_clr, bod_s, qual, clear_ok;

  por_seq_filt #(.BOD_FILT(BOD_FILT)) u_filt (
    .clk_i      (osc_ck),
    .rsb_i      (rsb),
    .bod_trip_i (bod_trip),
    .clr_i      (filt_clr),
    .bod_s_o    (bod_s),
    .qual_o     (qual),
    .clear_o    (clear_ok)
  );

  always_comb begin
    state_d  = state_q;
    rst_n_d  = rst_n_q;
    otrip_d  = otrip_q;
    ack_d    = 1'b0;
    evt_d    = 1'b0;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    blank_d  = blank_q;
    idx_d    = idx_q;
    filt_clr = (state_q == BLANK);
    // Losing POR overrides every other transition.
    if (state_q != WAIT_POR && !por_timed_out) begin
      state_d = WAIT_POR;
      rst_n_d = '0;
    end else begin
      unique case (state_q)
        WAIT_POR: if (por_timed_out) begin
          state_d = STAGGER;
          gap_d   = '0;
          idx_d   = '0;
        end
        STAGGER: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            rst_n_d[idx_q] = 1'b1;
            gap_d          = '0;
            idx_d          = idx_q + 1'b1;
            if (idx_q == IDX_W'(N_DOM - 1)) state_d = RUN;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN: begin
          if (qual) begin
            rst_n_d = '0;
            evt_d   = 1'b1;
            cnt_d   = sat_inc(cnt_q);
            state_d = BROWNOUT;
          end else if (cfg_req) begin
            otrip_d  = cfg_otrip;
            ack_d    = 1'b1;
            filt_clr = 1'b1;
            blank_d  = '0;
            state_d  = BLANK;
          end
        end
        BLANK: begin
          if (blank_q == BW'(BLANK_CYCLES - 1)) state_d = RUN;
          else                                  blank_d = blank_q + 1'b1;
        end
        BROWNOUT: begin
`ifdef POR_SEQ_BOD_STICKY_EN
          if (clear_ok && cfg_req) begin
            otrip_d = cfg_otrip;
            ack_d   = 1'b1;
            state_d = STAGGER;
            gap_d   = '0;
            idx_d   = '0;
          end
`else
          if (clear_ok) begin
            state_d = STAGGER;
            gap_d   = '0;
            idx_d   = '0;
          end
`endif
        end
        default: begin
          state_d = WAIT_POR;
          rst_n_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge osc_ck) begin
    if (!rsb) begin
      state_q <= WAIT_POR;
      rst_n_q <= '0;
      otrip_q <= OTRIP_RST;
      ack_q   <= 1'b0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
      blank_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rst_n_q <= rst_n_d;
      otrip_q <= otrip_d;
      ack_q   <= ack_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      blank_q <= blank_d;
      idx_q   <= idx_d;
    end
  end

  assign cfg_ack   = ack_q;
  assign otrip     = otrip_q;
  assign rst_n     = rst_n_q;
  assign bod_event = evt_q;
  assign bod_count = cnt_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_por_seq.sv
// Bench for por_seq: cycle-level reference model checked every cycle, plus
// directed literal checks on release timing, brownout, config and saturation.
module tb_por_seq;

  localparam int N = 4, G = 16, BL = 32, F = 4;

  logic       clk = 1'b0;
  logic       rsb, por, bod, req;
  logic [2:0] cotrip;
  logic       cfg_ack, bod_event;
  logic [2:0] otrip, seq_state;
  logic [N-1:0] rst_n;
  logic [7:0] bod_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  por_seq #(.N_DOM(N), .GAP_CYCLES(G), .BLANK_CYCLES(BL), .BOD_FILT(F), .OTRIP_RST(3'b011)) dut (
    .osc_ck(clk), .rsb(rsb), .por_timed_out(por), .bod_trip(bod),
    .cfg_req(req), .cfg_otrip(cotrip), .cfg_ack(cfg_ack), .otrip(otrip),
    .rst_n(rst_n), .bod_event(bod_event), .bod_count(bod_count), .seq_state(seq_state)
  );

  // Reference model: release mask derived from elapsed stagger time,
  // brownout qualification from run lengths of the delayed comparator level.
  bit         started = 0;
  int         m_state, st_cnt, bl_cnt, hi, lo;
  logic [N-1:0] m_rst;
  logic [2:0] m_otrip;
  logic [7:0] m_cnt;
  bit         m_ack, m_evt;
  bit         dly[2];

  always @(posedge clk) begin
    bit bs, qual, cok, clr;
    bs = dly[1]; qual = (hi == F); cok = (lo == F);
    clr = (m_state == 3);
    m_ack = 0; m_evt = 0;
    if (!rsb) begin
      started = 1; m_state = 0; m_rst = '0; m_otrip = 3'b011; m_cnt = 0;
      st_cnt = 0; bl_cnt = 0; hi = 0; lo = 0; dly[0] = 0; dly[1] = 0;
    end else begin
      if (m_state != 0 && !por) begin
        m_state = 0; m_rst = '0;
      end else begin
        case (m_state)
          0: if (por) begin m_state = 1; st_cnt = 0; end
          1: begin
            st_cnt++;
            m_rst = N'((1 << (st_cnt / G)) - 1);
            if (st_cnt == N * G) m_state = 2;
          end
          2: if (qual) begin
            m_rst = '0; m_evt = 1; if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1; m_state = 4;
          end else if (req) begin
            m_otrip = cotrip; m_ack = 1; clr = 1; bl_cnt = 0; m_state = 3;
          end
          3: begin bl_cnt++; if (bl_cnt == BL) m_state = 2; end
          4: begin
`ifdef POR_SEQ_BOD_STICKY_EN
            if (cok && req) begin m_otrip = cotrip; m_ack = 1; m_state = 1; st_cnt = 0; end
`else
            if (cok) begin m_state = 1; st_cnt = 0; end
`endif
          end
          default: m_state = 0;
        endcase
      end
      hi = (clr || !bs) ? 0 : ((hi < F) ? hi + 1 : F);
      lo = bs ? 0 : ((lo < F) ? lo + 1 : F);
      dly[1] = dly[0]; dly[0] = bod;
    end
  end

  always @(negedge clk) if (started) begin
    checks++;
    if ({rst_n, otrip, cfg_ack, bod_event, bod_count, seq_state} !==
        {m_rst, m_otrip, m_ack, m_evt, m_cnt, 3'(m_state)}) begin
      errors++;
      $display("FAIL model t=%0t: got rst_n=%b otrip=%b ack=%b evt=%b cnt=%0d st=%0d want rst_n=%b otrip=%b ack=%b evt=%b cnt=%0d st=%0d",
               $time, rst_n, otrip, cfg_ack, bod_event, bod_count, seq_state,
               m_rst, m_otrip, m_ack, m_evt, m_cnt, m_state);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_run(input int budget, input string nm);
    int n = 0;
    while (seq_state != 3'd2 && n < budget) begin
`ifdef POR_SEQ_BOD_STICKY_EN
      if (cfg_ack) req = 0;
      else if (seq_state == 3'd4) req = 1;
`endif
      tick(); n++;
    end
    req = 0;
    check(nm, seq_state, 2);
  endtask

  initial begin
    int n;
    rsb = 0; por = 0; bod = 0; req = 0; cotrip = 3'b000;
    repeat (3) tick();
    check("rst_rst_n", rst_n, 0);
    check("rst_otrip", otrip, 3'b011);
    check("rst_state", seq_state, 0);
    check("rst_count", bod_count, 0);
    rsb = 1;
    repeat (10) tick();
    por = 1;
    repeat (16) tick(); check("rel0_early", rst_n, 4'b0000);
    tick();             check("rel0_c27", rst_n, 4'b0001);
    repeat (16) tick(); check("rel1_c43", rst_n, 4'b0011);
    repeat (16) tick(); check("rel2_c59", rst_n, 4'b0111);
    check("stagger_state", seq_state, 1);
    repeat (16) tick(); check("rel3_c75", rst_n, 4'b1111);
    check("run_c75", seq_state, 2);

    // short glitch is filtered out
    bod = 1; repeat (3) tick(); bod = 0;
    repeat (10) tick();
    check("glitch_state", seq_state, 2);
    check("glitch_cnt", bod_count, 0);

    // qualified brownout: rst_n drops at E0+6
    bod = 1;
    repeat (6) tick(); check("bod_e5", rst_n, 4'b1111);
    tick();
    check("bod_e6_rst", rst_n, 4'b0000);
    check("bod_e6_evt", bod_event, 1);
    check("bod_e6_cnt", bod_count, 1);
    check("bod_e6_st", seq_state, 4);
    tick(); check("bod_evt_once", bod_event, 0);
    repeat (2) tick();
    bod = 0;
`ifdef POR_SEQ_BOD_STICKY_EN
    repeat (20) tick();
    check("sticky_hold", seq_state, 4);
    cotrip = 3'b101; req = 1;
    tick();
    check("sticky_ack", cfg_ack, 1);
    check("sticky_otrip", otrip, 3'b101);
    check("sticky_stagger", seq_state, 1);
    req = 0;
`endif
    wait_run(200, "bod_recover");
    check("bod_rerelease", rst_n, 4'b1111);

    // config update followed by blanked brownout activity
    cotrip = 3'b110; req = 1;
    tick();
    check("cfg_ack", cfg_ack, 1);
    check("cfg_otrip", otrip, 3'b110);
    check("cfg_blank", seq_state, 3);
    req = 0; bod = 1;
    tick(); check("cfg_ack_once", cfg_ack, 0);
    repeat (29) tick();
    bod = 0;
    repeat (10) tick();
    check("blank_no_evt_cnt", bod_count, 1);
    check("blank_back_run", seq_state, 2);

    // POR loss in RUN, then a request pending through STAGGER
    por = 0; tick();
    check("porloss_run_rst", rst_n, 0);
    check("porloss_run_st", seq_state, 0);
    por = 1; cotrip = 3'b001; req = 1;
    repeat (17) tick();
    check("pend_rel0", rst_n, 4'b0001);
    check("pend_no_ack", cfg_ack, 0);
    n = 17;
    while (!cfg_ack && n < 120) begin tick(); n++; end
    req = 0;
    check("pend_ack_latency", n, 66);
    check("pend_otrip", otrip, 3'b001);
    check("pend_blank", seq_state, 3);
    tick(); check("pend_ack_once", cfg_ack, 0);

    // POR loss in BLANK
    por = 0; tick();
    check("porloss_blank_st", seq_state, 0);
    check("porloss_blank_rst", rst_n, 0);
    por = 1;
    repeat (16) tick(); check("porloss_rel0_early", rst_n, 4'b0000);
    tick();             check("porloss_rel0", rst_n, 4'b0001);
    wait_run(100, "porloss_recover");

    // counter saturation
    for (int i = 0; i < 260; i++) begin
      bod = 1; repeat (8) tick(); bod = 0;
      wait_run(200, "sat_recover");
    end
    check("sat_count", bod_count, 255);

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
